// File: rtl/counter_cmd_driver.sv
// Command-driven stimulus engine for clear_counter-style counters: queues LOAD/INC/WAIT
// commands, expands them into registered ld/inc strobes and checks q against a shadow model.
module counter_cmd_driver #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_arg,
   output logic              ld,
   output logic              inc,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] q_in,
   output logic              busy,
   output logic [DATA_W-1:0] exp_q,
   output logic              mismatch,
   output logic [7:0]        mismatch_cnt
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = DATA_W + 2;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_INC  = 2'b10;
   localparam logic [1:0] OP_WAIT = 2'b11;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_INC  = 2'd2;
   localparam logic [1:0] S_WAIT = 2'd3;

   logic [ENT_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [ENT_W-1:0]  head;
   logic [1:0]        head_op;
   logic [DATA_W-1:0] head_arg;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] rem_nxt;
   logic              ld_nxt;
   logic              inc_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              check_en;

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign busy      = !empty || (state != S_IDLE);
   assign head      = mem[rd_ptr];
   assign head_op   = head[ENT_W-1 -: 2];
   assign head_arg  = head[DATA_W-1:0];

   // FIFO storage carries no reset; only the pointers define its contents
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_op, cmd_arg};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Strobes are computed one cycle ahead so ld/inc/data_out come straight from flops
   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      ld_nxt    = 1'b0;
      inc_nxt   = 1'b0;
      data_nxt  = data_out;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               case (head_op)
                  OP_LOAD: begin
                     state_nxt = S_LOAD;
                     ld_nxt    = 1'b1;
                     data_nxt  = head_arg;
                  end
                  OP_INC: begin
                     if (head_arg != '0) begin
                        state_nxt = S_INC;
                        rem_nxt   = head_arg;
                        inc_nxt   = 1'b1;
                     end
                  end
                  OP_WAIT: begin
                     if (head_arg != '0) begin
                        state_nxt = S_WAIT;
                        rem_nxt   = head_arg;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_LOAD: state_nxt = S_IDLE;
         S_INC: begin
            if (rem == DATA_W'(1)) begin
               state_nxt = S_IDLE;
            end else begin
               rem_nxt = rem - DATA_W'(1);
               inc_nxt = 1'b1;
            end
         end
         S_WAIT: begin
            if (rem == DATA_W'(1)) state_nxt = S_IDLE;
            else                   rem_nxt   = rem - DATA_W'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         rem      <= '0;
         ld       <= 1'b0;
         inc      <= 1'b0;
         data_out <= '0;
      end else begin
         state    <= state_nxt;
         rem      <= rem_nxt;
         ld       <= ld_nxt;
         inc      <= inc_nxt;
         data_out <= data_nxt;
      end
   end

   // Shadow counter and checker track the same edge at which the counter samples ld/inc
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q        <= '0;
         check_en     <= 1'b0;
         mismatch     <= 1'b0;
         mismatch_cnt <= '0;
      end else begin
         if (ld)       exp_q <= data_out;
         else if (inc) exp_q <= exp_q + DATA_W'(1);
         if (ld) check_en <= 1'b1;
         if (check_en && (q_in != exp_q)) begin
            mismatch <= 1'b1;
            if (mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_counter_cmd_driver.sv
// Directed bench for counter_cmd_driver: a reference counter closes the q loop, a vector
// table covers single commands and hand sequences cover latency, backpressure and checking.
module tb_counter_cmd_driver;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_INC  = 2'b10;
   localparam logic [1:0] OP_WAIT = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_arg;
   logic       ld;
   logic       inc;
   logic [7:0] data_out;
   logic [7:0] q_in;
   logic       busy;
   logic [7:0] exp_q;
   logic       mismatch;
   logic [7:0] mismatch_cnt;

   logic [7:0] cnt_q;
   logic       force_q;
   logic       log_en;
   logic [8:0] evq[$];
   int         both_cnt;
   int         total;
   int         bad;

   typedef struct {
      logic [1:0] op;
      logic [7:0] arg;
      int         n_ld;
      int         n_inc;
      int         first;
      int         n_busy;
      int         data;
      int         q;
   } vec_t;

   vec_t vecs[9];

   counter_cmd_driver #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ld(ld), .inc(inc), .data_out(data_out),
      .q_in(q_in), .busy(busy), .exp_q(exp_q), .mismatch(mismatch),
      .mismatch_cnt(mismatch_cnt)
   );

   always #5 clk = ~clk;

   // Reference clear_counter; force_q overrides its q to inject compare errors
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     cnt_q <= 8'h00;
      else if (ld)  cnt_q <= data_out;
      else if (inc) cnt_q <= cnt_q + 8'd1;
   end
   assign q_in = force_q ? 8'h00 : cnt_q;

   always @(negedge clk) begin
      if (ld && inc) both_cnt++;
      if (log_en) begin
         if (ld)  evq.push_back({1'b1, data_out});
         if (inc) evq.push_back({1'b0, exp_q});
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the command was accepted
   task automatic push(input logic [1:0] op, input logic [7:0] arg);
      int k;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      k = 0;
      while (!cmd_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) chk("push_timeout", 0, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ld_mask;
      logic [15:0] inc_mask;
      logic [7:0]  seen_data;
      logic [7:0]  q_c2;
      logic [7:0]  q_c3;
      logic [8:0]  exp_ev[8];
      int n_ld, n_inc, n_busy, first;

      rst = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 8'h00;
      force_q = 1'b0; log_en = 1'b0; both_cnt = 0; total = 0; bad = 0;

      vecs[0] = '{OP_LOAD, 8'h5A, 1, 0, 2, 2, 8'h5A, 8'h5A};
      vecs[1] = '{OP_INC,  8'h03, 0, 3, 2, 4, -1,    8'h5D};
      vecs[2] = '{OP_WAIT, 8'h05, 0, 0, 0, 6, -1,    8'h5D};
      vecs[3] = '{OP_NOP,  8'h77, 0, 0, 0, 1, -1,    8'h5D};
      vecs[4] = '{OP_INC,  8'h00, 0, 0, 0, 1, -1,    8'h5D};
      vecs[5] = '{OP_LOAD, 8'hFE, 1, 0, 2, 2, 8'hFE, 8'hFE};
      vecs[6] = '{OP_INC,  8'h03, 0, 3, 2, 4, -1,    8'h01};
      vecs[7] = '{OP_WAIT, 8'h00, 0, 0, 0, 1, -1,    8'h01};
      vecs[8] = '{OP_INC,  8'h01, 0, 1, 2, 2, -1,    8'h02};

      // Reset values while held
      repeat (3) @(negedge clk);
      chk("rst_ld", int'(ld), 0);
      chk("rst_inc", int'(inc), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_exp_q", int'(exp_q), 0);
      chk("rst_mismatch", int'(mismatch), 0);
      chk("rst_mismatch_cnt", int'(mismatch_cnt), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      rst = 1'b1;
      @(negedge clk);

      // Reset in the middle of INC 200
      push(OP_INC, 8'd200);
      repeat (10) @(negedge clk);
      chk("midinc_inc", int'(inc), 1);
      chk("midinc_exp_q", int'(exp_q), 9);
      rst = 1'b0;
      #1;
      chk("abort_ld", int'(ld), 0);
      chk("abort_inc", int'(inc), 0);
      chk("abort_exp_q", int'(exp_q), 0);
      chk("abort_cmd_ready", int'(cmd_ready), 1);
      @(negedge clk);
      rst = 1'b1;
      force_q = 1'b1;
      n_ld = 0; n_inc = 0; n_busy = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 5) force_q = 1'b0;
         n_ld += int'(ld);
         n_inc += int'(inc);
         n_busy += int'(busy);
         @(negedge clk);
      end
      chk("post_rst_ld", n_ld, 0);
      chk("post_rst_inc", n_inc, 0);
      chk("post_rst_busy", n_busy, 0);
      chk("no_check_before_load", int'(mismatch), 0);

      // LOAD 0x5A latency
      ld_mask = '0; seen_data = 8'h00; q_c2 = 8'hEE; q_c3 = 8'hEE;
      for (int c = 0; c < 7; c++) begin
         cmd_valid = (c == 0); cmd_op = OP_LOAD; cmd_arg = 8'h5A;
         if (ld) begin
            ld_mask[c] = 1'b1;
            seen_data = data_out;
         end
         if (c == 2) q_c2 = exp_q;
         if (c == 3) q_c3 = exp_q;
         @(negedge clk);
      end
      chk("load_ld_mask", int'(ld_mask), 16'h0004);
      chk("load_data_out", int'(seen_data), 8'h5A);
      chk("load_exp_q_c2", int'(q_c2), 8'h00);
      chk("load_exp_q_c3", int'(q_c3), 8'h5A);

      // LOAD 0xFD then INC 4 back-to-back, wrapping through 0xFF
      ld_mask = '0; inc_mask = '0;
      for (int c = 0; c < 13; c++) begin
         cmd_valid = (c < 2);
         cmd_op    = (c == 0) ? OP_LOAD : OP_INC;
         cmd_arg   = (c == 0) ? 8'hFD : 8'h04;
         if (ld)  ld_mask[c] = 1'b1;
         if (inc) inc_mask[c] = 1'b1;
         @(negedge clk);
      end
      chk("wrap_ld_mask", int'(ld_mask), 16'h0004);
      chk("wrap_inc_mask", int'(inc_mask), 16'h00F0);
      chk("wrap_exp_q", int'(exp_q), 8'h01);
      chk("wrap_mismatch", int'(mismatch), 0);

      // Single-command vectors
      for (int v = 0; v < 9; v++) begin
         push(vecs[v].op, vecs[v].arg);
         n_ld = 0; n_inc = 0; n_busy = 0; first = 0; seen_data = 8'h00;
         for (int c = 1; c < 30; c++) begin
            if ((ld || inc) && first == 0) first = c;
            if (ld) seen_data = data_out;
            n_ld += int'(ld);
            n_inc += int'(inc);
            n_busy += int'(busy);
            @(negedge clk);
         end
         chk($sformatf("vec%0d_n_ld", v), n_ld, vecs[v].n_ld);
         chk($sformatf("vec%0d_n_inc", v), n_inc, vecs[v].n_inc);
         chk($sformatf("vec%0d_first", v), first, vecs[v].first);
         chk($sformatf("vec%0d_n_busy", v), n_busy, vecs[v].n_busy);
         chk($sformatf("vec%0d_exp_q", v), int'(exp_q), vecs[v].q);
         if (vecs[v].data >= 0) chk($sformatf("vec%0d_data", v), int'(seen_data), vecs[v].data);
      end

      // Backpressure: six commands queued behind WAIT 10
      evq.delete();
      log_en = 1'b1;
      push(OP_WAIT, 8'd10);
      push(OP_LOAD, 8'h30);
      push(OP_INC, 8'd2);
      push(OP_LOAD, 8'h40);
      push(OP_INC, 8'd1);
      chk("full_cmd_ready", int'(cmd_ready), 0);
      chk("full_busy", int'(busy), 1);
      push(OP_NOP, 8'h00);
      push(OP_INC, 8'd3);
      wait_idle();
      @(negedge clk);
      log_en = 1'b0;
      exp_ev = '{9'h130, 9'h030, 9'h031, 9'h140, 9'h040, 9'h041, 9'h042, 9'h043};
      chk("order_len", evq.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < evq.size()) chk($sformatf("order_ev%0d", i), int'(evq[i]), int'(exp_ev[i]));
         else chk($sformatf("order_ev%0d", i), -1, int'(exp_ev[i]));
      end
      chk("order_exp_q", int'(exp_q), 8'h44);

      // NOP / INC 0 / WAIT 0 consumed with no strobes, one fetch each
      ld_mask = '0; inc_mask = '0;
      for (int c = 0; c < 11; c++) begin
         cmd_valid = (c < 4);
         case (c)
            0:       begin cmd_op = OP_NOP;  cmd_arg = 8'h00; end
            1:       begin cmd_op = OP_INC;  cmd_arg = 8'h00; end
            2:       begin cmd_op = OP_WAIT; cmd_arg = 8'h00; end
            default: begin cmd_op = OP_LOAD; cmd_arg = 8'h03; end
         endcase
         if (ld)  ld_mask[c] = 1'b1;
         if (inc) inc_mask[c] = 1'b1;
         @(negedge clk);
      end
      chk("zero_ld_mask", int'(ld_mask), 16'h0020);
      chk("zero_inc_mask", int'(inc_mask), 16'h0000);
      chk("zero_exp_q", int'(exp_q), 8'h03);

      // Forced counter error for three cycles
      push(OP_LOAD, 8'h10);
      wait_idle();
      chk("pre_force_mismatch", int'(mismatch), 0);
      chk("pre_force_exp_q", int'(exp_q), 8'h10);
      force_q = 1'b1;
      repeat (3) @(negedge clk);
      force_q = 1'b0;
      chk("force_mismatch", int'(mismatch), 1);
      chk("force_mismatch_cnt", int'(mismatch_cnt), 3);
      repeat (4) @(negedge clk);
      chk("sticky_mismatch", int'(mismatch), 1);
      chk("sticky_mismatch_cnt", int'(mismatch_cnt), 3);

      chk("ld_inc_exclusive", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
